// File: rtl/alu_issue_pkg.sv
// alu_issue_pkg: shared FSM state type, ALU op codes and highest legal op for alu_issue
package alu_issue_pkg;
  // One-bit-step encoding: each legal transition flips a single bit, so the
  // state decodes below are glitch-free.
  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    ISSUE   = 2'b01,
    CAPTURE = 2'b11,
    RESPOND = 2'b10
  } state_e;
  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_NOT = 4'd5;
  localparam logic [3:0] OP_INC = 4'd6;
  localparam logic [3:0] OP_DEC = 4'd7;
  localparam int OP_MAX = 7;
endpackage

// File: rtl/alu_issue.sv
// alu_issue: issues one request at a time to an external ALU and returns its result and flags
//   clk, reset_n                          clock, async active-low reset
//   req_valid/ready/op/a/b/use_carry      request handshake and payload
//   alu_in_1/in_2/select/enable/carry_in  drive to external ALU
//   alu_data/carry_out/zero               ALU result inputs
//   rsp_valid/ready/data/err              response handshake and payload
//   flag_carry, flag_zero                 stored ALU flags
module alu_issue #(
  parameter int DATA_W = 16,
  parameter int OP_MAX = alu_issue_pkg::OP_MAX
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [3:0]        req_op,
  input  logic [DATA_W-1:0] req_a,
  input  logic [DATA_W-1:0] req_b,
  input  logic              req_use_carry,
  output logic [DATA_W-1:0] alu_in_1,
  output logic [DATA_W-1:0] alu_in_2,
  output logic [3:0]        alu_select,
  output logic              alu_enable,
  output logic              alu_carry_in,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              alu_carry_out,
  input  logic              alu_zero,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  output logic              flag_carry,
  output logic              flag_zero
);
  import alu_issue_pkg::*;
  state_e            state_q, state_d;
  logic              rdy_q, rdy_d;
  logic [3:0]        op_q, op_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d, data_q, data_d;
  logic              cin_q, cin_d, err_q, err_d, fc_q, fc_d, fz_q, fz_d;
  logic              hs, legal;
  assign req_ready    = rdy_q && state_q == IDLE;
  assign rsp_valid    = state_q == RESPOND;
  assign alu_enable   = state_q[0];
  assign alu_in_1     = a_q;
  assign alu_in_2     = b_q;
  assign alu_select   = op_q;
  assign alu_carry_in = cin_q;
  assign rsp_data     = data_q;
  assign rsp_err      = err_q;
  assign flag_carry   = fc_q;
  assign flag_zero    = fz_q;
  assign hs           = req_valid && req_ready;
  assign legal        = int'(req_op) <= OP_MAX;
  always_comb begin
    state_d = state_q;
    rdy_d   = 1'b1;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    cin_d   = cin_q;
    data_d  = data_q;
    err_d   = err_q;
    fc_d    = fc_q;
    fz_d    = fz_q;
    case (state_q)
      IDLE: if (hs) begin
        // Illegal ops leave the ALU-side registers untouched so the bus holds still.
        if (legal) begin
          state_d = ISSUE;
          op_d    = req_op;
          a_d     = req_a;
          b_d     = req_b;
          cin_d   = req_use_carry && fc_q;
          err_d   = 1'b0;
        end else begin
          state_d = RESPOND;
          err_d   = 1'b1;
          data_d  = '0;
        end
      end
      ISSUE: state_d = CAPTURE;
      CAPTURE: begin
        state_d = RESPOND;
        data_d  = alu_data;
        fc_d    = alu_carry_out;
        fz_d    = alu_zero;
      end
      default: state_d = rsp_ready ? IDLE : RESPOND;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      rdy_q   <= 1'b0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      cin_q   <= 1'b0;
      data_q  <= '0;
      err_q   <= 1'b0;
      fc_q    <= 1'b0;
      fz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      rdy_q   <= rdy_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cin_q   <= cin_d;
      data_q  <= data_d;
      err_q   <= err_d;
      fc_q    <= fc_d;
      fz_q    <= fz_d;
    end
  end
endmodule

// File: tb/tb_alu_issue.sv
// tb_alu_issue: directed self-checking bench for alu_issue with a behavioural ALU attached
module tb_alu_issue;
  import alu_issue_pkg::*;
  logic        clk, reset_n;
  logic        req_valid, req_ready, req_use_carry;
  logic [3:0]  req_op;
  logic [15:0] req_a, req_b;
  logic [15:0] alu_in_1, alu_in_2, alu_data;
  logic [3:0]  alu_select;
  logic        alu_enable, alu_carry_in, alu_carry_out, alu_zero;
  logic        rsp_valid, rsp_ready, rsp_err, flag_carry, flag_zero;
  logic [15:0] rsp_data;
  logic [16:0] alu_r;
  int          checks = 0;
  int          errors = 0;

  alu_issue #(.DATA_W(16), .OP_MAX(7)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_use_carry(req_use_carry),
    .alu_in_1(alu_in_1), .alu_in_2(alu_in_2), .alu_select(alu_select),
    .alu_enable(alu_enable), .alu_carry_in(alu_carry_in),
    .alu_data(alu_data), .alu_carry_out(alu_carry_out), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_err(rsp_err), .flag_carry(flag_carry), .flag_zero(flag_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    alu_r = '0;
    case (alu_select)
      OP_ADD:  alu_r = {1'b0, alu_in_1} + {1'b0, alu_in_2} + {16'd0, alu_carry_in};
      OP_SUB:  alu_r = {1'b0, alu_in_1} - {1'b0, alu_in_2} - {16'd0, alu_carry_in};
      OP_AND:  alu_r = {1'b0, alu_in_1 & alu_in_2};
      OP_OR:   alu_r = {1'b0, alu_in_1 | alu_in_2};
      OP_XOR:  alu_r = {1'b0, alu_in_1 ^ alu_in_2};
      OP_NOT:  alu_r = {1'b0, ~alu_in_1};
      OP_INC:  alu_r = {1'b0, alu_in_1} + 17'd1;
      OP_DEC:  alu_r = {1'b0, alu_in_1} - 17'd1;
      default: alu_r = '0;
    endcase
  end
  assign alu_data      = alu_r[15:0];
  assign alu_carry_out = alu_r[16];
  assign alu_zero      = alu_r[15:0] == 16'd0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b, input logic uc);
    int n = 0;
    req_valid = 1'b1;
    req_op = op;
    req_a = a;
    req_b = b;
    req_use_carry = uc;
    while (!req_ready && n < 10) begin
      tick();
      n++;
    end
    check("req_ready_wait", {31'd0, req_ready}, 32'd1);
    tick();
    req_valid = 1'b0;
  endtask

  task automatic run(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b, input logic uc);
    send(op, a, b, uc);
    tick();
    tick();
    check("run_rsp_valid", {31'd0, rsp_valid}, 32'd1);
  endtask

  task automatic release_rsp();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("rel_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rel_req_ready", {31'd0, req_ready}, 32'd1);
  endtask

  initial begin
    reset_n = 1'b0;
    req_valid = 1'b0;
    req_op = '0;
    req_a = '0;
    req_b = '0;
    req_use_carry = 1'b0;
    rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_req_ready", {31'd0, req_ready}, 32'd0);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
    check("rst_alu_enable", {31'd0, alu_enable}, 32'd0);
    check("rst_carry_in", {31'd0, alu_carry_in}, 32'd0);
    check("rst_flag_carry", {31'd0, flag_carry}, 32'd0);
    check("rst_flag_zero", {31'd0, flag_zero}, 32'd0);
    check("rst_rsp_data", {16'd0, rsp_data}, 32'd0);
    check("rst_alu_in_1", {16'd0, alu_in_1}, 32'd0);
    check("rst_alu_in_2", {16'd0, alu_in_2}, 32'd0);
    check("rst_alu_select", {28'd0, alu_select}, 32'd0);
    reset_n = 1'b1;
    #1;
    check("ready_before_edge", {31'd0, req_ready}, 32'd0);
    tick();
    check("ready_after_edge", {31'd0, req_ready}, 32'd1);
    // ADD 3+4, exact latency
    send(OP_ADD, 16'h0003, 16'h0004, 1'b0);
    check("add_issue_en", {31'd0, alu_enable}, 32'd1);
    check("add_in_1", {16'd0, alu_in_1}, 32'h0003);
    check("add_in_2", {16'd0, alu_in_2}, 32'h0004);
    check("add_select", {28'd0, alu_select}, 32'd0);
    check("add_issue_valid", {31'd0, rsp_valid}, 32'd0);
    check("add_issue_ready", {31'd0, req_ready}, 32'd0);
    tick();
    check("add_capture_en", {31'd0, alu_enable}, 32'd1);
    check("add_capture_valid", {31'd0, rsp_valid}, 32'd0);
    check("add_capture_in_1", {16'd0, alu_in_1}, 32'h0003);
    tick();
    check("add_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    check("add_rsp_data", {16'd0, rsp_data}, 32'h0007);
    check("add_carry", {31'd0, flag_carry}, 32'd0);
    check("add_zero", {31'd0, flag_zero}, 32'd0);
    check("add_err", {31'd0, rsp_err}, 32'd0);
    check("add_rsp_en", {31'd0, alu_enable}, 32'd0);
    check("add_rsp_in_1_held", {16'd0, alu_in_1}, 32'h0003);
    release_rsp();
    // carry out of FFFF+1
    run(OP_ADD, 16'hFFFF, 16'h0001, 1'b0);
    check("wrap_data", {16'd0, rsp_data}, 32'h0000);
    check("wrap_carry", {31'd0, flag_carry}, 32'd1);
    check("wrap_zero", {31'd0, flag_zero}, 32'd1);
    release_rsp();
    // illegal op: one-cycle error response, flags and ALU bus untouched
    send(4'hA, 16'h0005, 16'h0006, 1'b0);
    check("ill_valid", {31'd0, rsp_valid}, 32'd1);
    check("ill_err", {31'd0, rsp_err}, 32'd1);
    check("ill_data", {16'd0, rsp_data}, 32'd0);
    check("ill_en", {31'd0, alu_enable}, 32'd0);
    check("ill_carry_kept", {31'd0, flag_carry}, 32'd1);
    check("ill_zero_kept", {31'd0, flag_zero}, 32'd1);
    check("ill_in_1_held", {16'd0, alu_in_1}, 32'hFFFF);
    release_rsp();
    check("ill_post_en", {31'd0, alu_enable}, 32'd0);
    // carry chained in: 1+1+1
    send(OP_ADD, 16'h0001, 16'h0001, 1'b1);
    check("chain_carry_in", {31'd0, alu_carry_in}, 32'd1);
    check("chain_err_cleared", {31'd0, rsp_err}, 32'd0);
    tick();
    tick();
    check("chain_data", {16'd0, rsp_data}, 32'h0003);
    check("chain_carry", {31'd0, flag_carry}, 32'd0);
    check("chain_zero", {31'd0, flag_zero}, 32'd0);
    release_rsp();
    // backpressure on SUB 10-3
    run(OP_SUB, 16'h000A, 16'h0003, 1'b0);
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", {31'd0, rsp_valid}, 32'd1);
      check("bp_data", {16'd0, rsp_data}, 32'h0007);
      check("bp_req_ready", {31'd0, req_ready}, 32'd0);
      tick();
    end
    release_rsp();
    // back-to-back XOR then DEC
    run(OP_XOR, 16'h0005, 16'h0005, 1'b0);
    check("xor_data", {16'd0, rsp_data}, 32'h0000);
    check("xor_zero", {31'd0, flag_zero}, 32'd1);
    check("xor_carry", {31'd0, flag_carry}, 32'd0);
    release_rsp();
    run(OP_DEC, 16'h0000, 16'h0000, 1'b0);
    check("dec_data", {16'd0, rsp_data}, 32'hFFFF);
    check("dec_carry", {31'd0, flag_carry}, 32'd1);
    check("dec_zero", {31'd0, flag_zero}, 32'd0);
    release_rsp();
    // reset asserted while in CAPTURE
    send(OP_ADD, 16'h0002, 16'h0002, 1'b0);
    tick();
    check("mid_capture_en", {31'd0, alu_enable}, 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("mid_rst_en", {31'd0, alu_enable}, 32'd0);
    check("mid_rst_valid", {31'd0, rsp_valid}, 32'd0);
    check("mid_rst_carry", {31'd0, flag_carry}, 32'd0);
    check("mid_rst_zero", {31'd0, flag_zero}, 32'd0);
    check("mid_rst_data", {16'd0, rsp_data}, 32'd0);
    check("mid_rst_in_1", {16'd0, alu_in_1}, 32'd0);
    check("mid_rst_ready", {31'd0, req_ready}, 32'd0);
    tick();
    check("mid_rst_valid_edge", {31'd0, rsp_valid}, 32'd0);
    reset_n = 1'b1;
    tick();
    check("post_rst_ready", {31'd0, req_ready}, 32'd1);
    check("post_rst_valid", {31'd0, rsp_valid}, 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_issue.md
ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 The module SHALL have parameter DATA_W, default 16, as the operand/result width.
REQ-002 The module SHALL have parameter OP_MAX, default 7, as the highest legal ALU select code.
REQ-003 Clock and reset: one clock, reset asynchronous and active-low.
- clk  in  1  sole clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
REQ-004 Request ports SHALL be:
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when valid and ready both high.
- req_op  in  4  ALU select code.
- req_a  in  DATA_W  operand 1.
- req_b  in  DATA_W  operand 2.
- req_use_carry  in  1  feed the stored carry flag into the ALU carry input.
REQ-005 ALU-side ports SHALL be:
- alu_in_1  out  DATA_W  operand 1 to ALU.
- alu_in_2  out  DATA_W  operand 2 to ALU.
- alu_select  out  4  op code to ALU.
- alu_enable  out  1  ALU bus enable.
- alu_carry_in  out  1  carry into ALU.
- alu_data  in  DATA_W  ALU result bus.
- alu_carry_out  in  1  ALU carry out.
- alu_zero  in  1  ALU zero flag.
REQ-006 Response ports SHALL be:
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer accepts.
- rsp_data  out  DATA_W  captured result.
- rsp_err  out  1  op code was illegal.
- flag_carry  out  1  stored carry flag.
- flag_zero  out  1  stored zero flag.

Function
REQ-007 FSM states SHALL be IDLE, ISSUE, CAPTURE, RESPOND.
REQ-008 req_ready SHALL be high only in IDLE; a handshake latches req_op, req_a, req_b and req_use_carry into internal registers.
REQ-009 Transition out of IDLE on handshake: to ISSUE if req_op <= OP_MAX, else to RESPOND with rsp_err=1 and rsp_data=0.
REQ-010 In ISSUE and CAPTURE, alu_enable SHALL be 1; alu_in_1/alu_in_2/alu_select SHALL be driven from the latched request and held stable throughout.
REQ-011 alu_enable SHALL be 0 in IDLE and RESPOND, and the ALU operand outputs SHALL be held at their last values, with no glitching.
REQ-012 alu_carry_in SHALL equal (latched req_use_carry AND flag_carry), sampled at handshake.
REQ-013 ISSUE SHALL last exactly one cycle, then move to CAPTURE.
REQ-014 In CAPTURE, at the clock edge, alu_data SHALL be latched into rsp_data, alu_carry_out into flag_carry and alu_zero into flag_zero; the FSM then moves to RESPOND.
REQ-015 In RESPOND, rsp_valid SHALL be 1 and rsp_data/rsp_err SHALL be stable until rsp_ready is high; the FSM then returns to IDLE.
REQ-016 Latency SHALL be three cycles from the handshake edge to rsp_valid for legal ops, and one cycle for illegal ops.
REQ-017 Illegal ops SHALL NOT assert alu_enable and SHALL NOT modify flag_carry or flag_zero.
REQ-018 The block SHALL hold only one request in flight; a back-to-back request is accepted the cycle after the rsp handshake at the earliest, when the FSM has returned to IDLE.
REQ-019 rsp_err SHALL be cleared on the next accepted legal request.

Reset
REQ-020 On reset_n low, state SHALL be IDLE, and req_ready, rsp_valid, rsp_err, alu_enable, alu_carry_in, flag_carry and flag_zero SHALL be 0; rsp_data, alu_in_1, alu_in_2 and alu_select SHALL be 0.
REQ-021 Reset asserted mid-operation SHALL abort the transaction immediately, without producing a response or updating any flag.
REQ-022 req_ready SHALL go high on the first clock edge after reset_n deasserts.

Structure
REQ-023 A shared package SHALL hold the state enum, the op code constants (ADD=0 ... DEC=7) and OP_MAX.
REQ-024 The module SHALL be a single module, with no sub-module, and SHALL instantiate no ALU; the ALU connects externally.

Verification
REQ-025 ADD: a=16'h0003, b=16'h0004, use_carry=0 -> rsp_data=16'h0007, carry=0, zero=0, rsp_valid 3 cycles after the handshake.
REQ-026 Carry chain: ADD 16'hFFFF+16'h0001 -> rsp_data=0, carry=1, zero=1; then ADD 1+1 with use_carry=1 -> rsp_data=16'h0003.
REQ-027 Illegal op 4'hA -> alu_enable never high, rsp_err=1, rsp_data=0 after 1 cycle, flags unchanged.
REQ-028 Backpressure: hold rsp_ready=0 for 5 cycles -> rsp_valid and rsp_data stable, req_ready=0; release -> IDLE, then the next request is accepted.
REQ-029 Reset during CAPTURE -> all outputs 0 next edge, no rsp_valid, flags 0.
REQ-030 Back-to-back XOR then DEC (a=0) -> results 16'h0000 (zero=1), then 16'hFFFF (carry=1), in order.
